// File: rtl/diagonal_walker.sv
// Diagonal X/Y grid walker: fold toward mid-range, swap or hold at the corner,
// and a sticky monitor that freezes the walk when the invariant x >= y breaks.
module diagonal_walker #(
  parameter int unsigned W  = 4,
  parameter int unsigned X0 = 1,
  parameter int unsigned Y0 = 0,
  parameter int unsigned CW = 2 * W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          fold,
  input  logic          mode,
  output logic [W-1:0]  x,
  output logic [W-1:0]  y,
  output logic          prop,
  output logic          viol,
  output logic [1:0]    status,
  output logic [CW-1:0] steps
);

  localparam logic [W-1:0]  KMAX      = {W{1'b1}};
  localparam logic [CW-1:0] STEPS_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HELD = 2'b01,
    ST_FAIL = 2'b10
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [W-1:0]  r_x;
  logic [W-1:0]  r_y;
  logic [W-1:0]  w_x_nx;
  logic [W-1:0]  w_y_nx;
  logic [W-1:0]  w_fold;
  logic          w_prop;
  logic          w_step;
  logic          w_viol_set;
  logic          r_viol;
  logic [CW-1:0] r_steps;

  assign w_prop = (r_x >= r_y);
  assign w_fold = (KMAX >> 1) + (r_x >> 1);

  // Next-state and step-rule selection; FAIL entry outranks every step rule.
  always_comb begin
    w_state_nx = r_state;
    w_x_nx     = r_x;
    w_y_nx     = r_y;
    w_step     = 1'b0;
    w_viol_set = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (!w_prop) begin
          w_state_nx = ST_FAIL;
          w_viol_set = 1'b1;
        end else if (en) begin
          if (fold && (r_x > r_y)) begin
            w_x_nx = w_fold;
            w_step = 1'b1;
          end else if (r_x < r_y) begin
            w_y_nx = r_y + W'(1);
            w_step = 1'b1;
          end else if ((r_x == r_y) || (r_x != KMAX)) begin
            w_x_nx = r_x + W'(1);
            w_y_nx = r_y + W'(1);
            w_step = 1'b1;
          end else if (!mode) begin
            w_x_nx = r_y;
            w_y_nx = r_x;
            w_step = 1'b1;
          end else begin
            w_state_nx = ST_HELD;
          end
        end
      end
      ST_HELD: begin
        // x > y is guaranteed here, so a fold always applies R1.
        if (en && fold) begin
          w_x_nx     = w_fold;
          w_step     = 1'b1;
          w_state_nx = ST_RUN;
        end
      end
      default: begin
        w_state_nx = ST_FAIL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_x     <= W'(X0);
      r_y     <= W'(Y0);
      r_viol  <= 1'b0;
      r_steps <= '0;
    end else begin
      r_state <= w_state_nx;
      r_x     <= w_x_nx;
      r_y     <= w_y_nx;
      r_viol  <= r_viol | w_viol_set;
      if (w_step && (r_steps != STEPS_MAX)) begin
        r_steps <= r_steps + CW'(1);
      end
    end
  end

  assign x      = r_x;
  assign y      = r_y;
  assign prop   = w_prop;
  assign viol   = r_viol;
  assign status = r_state;
  assign steps  = r_steps;

endmodule

// File: tb/tb_diagonal_walker.sv
// Table-driven bench for diagonal_walker (W=4): each row drives inputs for N
// edges, expectations go through a scoreboard queue and are compared at negedge.
module tb_diagonal_walker;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       fold;
  logic       mode;
  logic [3:0] x;
  logic [3:0] y;
  logic       prop;
  logic       viol;
  logic [1:0] status;
  logic [7:0] steps;

  int n_cmp = 0;
  int n_err = 0;

  diagonal_walker #(.W(4), .X0(1), .Y0(0), .CW(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .fold   (fold),
    .mode   (mode),
    .x      (x),
    .y      (y),
    .prop   (prop),
    .viol   (viol),
    .status (status),
    .steps  (steps)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_before;
    logic       en;
    logic       fold;
    logic       mode;
    int         n;
    logic [3:0] ex;
    logic [3:0] ey;
    logic [1:0] est;
    logic [7:0] esteps;
    logic       eviol;
  } vec_t;

  typedef struct {
    logic [3:0] ex;
    logic [3:0] ey;
    logic       eprop;
    logic [1:0] est;
    logic [7:0] esteps;
    logic       eviol;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".x"},      32'(x),      32'd1);
    chk({tag, ".y"},      32'(y),      32'd0);
    chk({tag, ".prop"},   32'(prop),   32'd1);
    chk({tag, ".viol"},   32'(viol),   32'd0);
    chk({tag, ".status"}, 32'(status), 32'd0);
    chk({tag, ".steps"},  32'(steps),  32'd0);
  endtask

  // Short low pulse between edges; values must change without any clk edge.
  task automatic reset_pulse(input string tag);
    reset = 1'b0;
    #2;
    chk_reset_vals(tag);
    reset = 1'b1;
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic e, input logic f, input logic m,
                              input int n, input logic [3:0] ex, input logic [3:0] ey,
                              input logic [1:0] st, input logic [7:0] sp, input logic v);
    vec_t t;
    t.rst_before = r; t.en = e; t.fold = f; t.mode = m; t.n = n;
    t.ex = ex; t.ey = ey; t.est = st; t.esteps = sp; t.eviol = v;
    return t;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Legacy walk to the corner, swap, then absorbing FAIL.
    vecs.push_back(mk(0, 1, 0, 0, 14, 4'd15, 4'd14, 2'd0, 8'd14, 0));
    vecs.push_back(mk(0, 1, 0, 0,  1, 4'd14, 4'd15, 2'd0, 8'd15, 0));
    vecs.push_back(mk(0, 1, 0, 0,  1, 4'd14, 4'd15, 2'd2, 8'd15, 1));
    vecs.push_back(mk(0, 1, 1, 1,  5, 4'd14, 4'd15, 2'd2, 8'd15, 1));
    // Guarded walk: HELD, mode toggle, unqualified fold, then fold out and wrap.
    vecs.push_back(mk(1, 1, 0, 1, 14, 4'd15, 4'd14, 2'd0, 8'd14, 0));
    vecs.push_back(mk(0, 1, 0, 1,  1, 4'd15, 4'd14, 2'd1, 8'd14, 0));
    vecs.push_back(mk(0, 1, 0, 1, 20, 4'd15, 4'd14, 2'd1, 8'd14, 0));
    vecs.push_back(mk(0, 1, 0, 0,  3, 4'd15, 4'd14, 2'd1, 8'd14, 0));
    vecs.push_back(mk(0, 0, 1, 1,  2, 4'd15, 4'd14, 2'd1, 8'd14, 0));
    vecs.push_back(mk(0, 1, 1, 1,  1, 4'd14, 4'd14, 2'd0, 8'd15, 0));
    vecs.push_back(mk(0, 1, 1, 1,  1, 4'd15, 4'd15, 2'd0, 8'd16, 0));
    vecs.push_back(mk(0, 1, 1, 1,  1, 4'd0,  4'd0,  2'd0, 8'd17, 0));
    vecs.push_back(mk(0, 1, 0, 0,  1, 4'd1,  4'd1,  2'd0, 8'd18, 0));
    // Fold in RUN, en=0 hold, then fold fixed point drives steps to saturation.
    vecs.push_back(mk(1, 1, 0, 0,   8, 4'd9,  4'd8, 2'd0, 8'd8,   0));
    vecs.push_back(mk(0, 1, 1, 0,   1, 4'd11, 4'd8, 2'd0, 8'd9,   0));
    vecs.push_back(mk(0, 0, 0, 0,   5, 4'd11, 4'd8, 2'd0, 8'd9,   0));
    vecs.push_back(mk(0, 1, 1, 0,   1, 4'd12, 4'd8, 2'd0, 8'd10,  0));
    vecs.push_back(mk(0, 1, 1, 0, 250, 4'd13, 4'd8, 2'd0, 8'd255, 0));
    vecs.push_back(mk(0, 1, 1, 1,   5, 4'd13, 4'd8, 2'd0, 8'd255, 0));
    vecs.push_back(mk(0, 1, 0, 0,   1, 4'd14, 4'd9, 2'd0, 8'd255, 0));

    reset = 1'b0; en = 1'b0; fold = 1'b0; mode = 1'b0;
    #12;
    chk_reset_vals("por");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      exp_t g;
      string tag;
      tag = $sformatf("row%0d", i);
      if (vecs[i].rst_before) reset_pulse({tag, ".rst"});
      en   = vecs[i].en;
      fold = vecs[i].fold;
      mode = vecs[i].mode;
      e.ex = vecs[i].ex; e.ey = vecs[i].ey; e.est = vecs[i].est;
      e.esteps = vecs[i].esteps; e.eviol = vecs[i].eviol;
      e.eprop = (vecs[i].ex >= vecs[i].ey);
      sb.push_back(e);
      repeat (vecs[i].n) @(posedge clk);
      @(negedge clk);
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL %s.sb: got empty scoreboard expected one entry", tag);
      end else begin
        g = sb.pop_front();
        chk({tag, ".x"},      32'(x),      32'(g.ex));
        chk({tag, ".y"},      32'(y),      32'(g.ey));
        chk({tag, ".prop"},   32'(prop),   32'(g.eprop));
        chk({tag, ".status"}, 32'(status), 32'(g.est));
        chk({tag, ".steps"},  32'(steps),  32'(g.esteps));
        chk({tag, ".viol"},   32'(viol),   32'(g.eviol));
      end
    end

    // Async reset while HELD, then one step to confirm the walk restarts.
    en = 1'b1; fold = 1'b0; mode = 1'b1;
    reset_pulse("hold_pre");
    repeat (14) @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("held.status", 32'(status), 32'd1);
    reset_pulse("held_rst");
    @(posedge clk);
    @(negedge clk);
    chk("restart.x",     32'(x),     32'd2);
    chk("restart.y",     32'(y),     32'd1);
    chk("restart.steps", 32'(steps), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
